// File: rtl/traffic_pkg.sv
// Shared traffic-light encodings, approach indices and preemption FSM states.
package traffic_pkg;

  typedef enum logic [1:0] {
    LIGHT_RED    = 2'b00,
    LIGHT_YELLOW = 2'b01,
    LIGHT_GREEN  = 2'b10
  } light_e;

  localparam int DIR_NS = 0;
  localparam int DIR_SN = 1;
  localparam int DIR_EW = 2;
  localparam int DIR_WE = 3;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_EXIT_YELLOW = 3'd1,
    ST_EXIT_RED    = 3'd2,
    ST_EV_GREEN    = 3'd3,
    ST_EV_YELLOW   = 3'd4,
    ST_EV_RED      = 3'd5
  } pre_state_e;

  // An approach is "lit" when it shows anything other than RED.
  function automatic logic is_lit(input logic [1:0] light);
    return light != LIGHT_RED;
  endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// Four-way round-robin arbiter; the pointer moves one past the winner only on grant_en_i.
module rr_arbiter4 (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req_i,
  input  logic       grant_en_i,
  output logic [3:0] grant_o
);

  logic [1:0] ptr_q, ptr_d, idx;

  always_comb begin
    grant_o = '0;
    ptr_d   = ptr_q;
    idx     = '0;
    // Scan farthest-first so the nearest requester at or after the pointer wins.
    for (int k = 3; k >= 0; k--) begin
      idx = ptr_q + 2'(k);
      if (req_i[idx]) begin
        grant_o = 4'b0001 << idx;
        if (grant_en_i) begin
          ptr_d = idx + 2'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/emergency_preemption_controller.sv
// Overrides the main controller's lights to give emergency vehicles a safe, timed green.
module emergency_preemption_controller
  import traffic_pkg::*;
#(
  parameter int YELLOW_CYCLES  = 3,
  parameter int ALL_RED_CYCLES = 2,
  parameter int MIN_EV_GREEN   = 8,
  parameter int MAX_EV_GREEN   = 40
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       EV_NS,
  input  logic       EV_SN,
  input  logic       EV_EW,
  input  logic       EV_WE,
  input  logic [1:0] ctl_NS_light,
  input  logic [1:0] ctl_SN_light,
  input  logic [1:0] ctl_EW_light,
  input  logic [1:0] ctl_WE_light,
  output logic [1:0] NS_light,
  output logic [1:0] SN_light,
  output logic [1:0] EW_light,
  output logic [1:0] WE_light,
  output logic       ctl_hold,
  output logic       preempt_active,
  output logic [3:0] ev_grant,
  output logic [2:0] current_state
);

  localparam int CW = $clog2(MAX_EV_GREEN + 1);

  pre_state_e      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      grant_q, grant_d;
  logic [3:0]      snap_q, snap_d;
  logic [3:0]      ev_req, arb_grant, ctl_lit, ctl_green;
  logic            arb_en, granted_req;
  logic [3:0][1:0] ctl_l, out_l;
  int              elapsed;

  assign ev_req = {EV_WE, EV_EW, EV_SN, EV_NS};

  always_comb begin
    ctl_l         = '0;
    ctl_l[DIR_NS] = ctl_NS_light;
    ctl_l[DIR_SN] = ctl_SN_light;
    ctl_l[DIR_EW] = ctl_EW_light;
    ctl_l[DIR_WE] = ctl_WE_light;
    for (int i = 0; i < 4; i++) begin
      ctl_lit[i]   = is_lit(ctl_l[i]);
      ctl_green[i] = (ctl_l[i] == LIGHT_GREEN);
    end
  end

  rr_arbiter4 u_arb (
    .clk        (clk),
    .rst        (rst),
    .req_i      (ev_req),
    .grant_en_i (arb_en),
    .grant_o    (arb_grant)
  );

  // Cycles spent in the current state including this one.
  assign elapsed     = int'(cnt_q) + 1;
  assign granted_req = |(ev_req & grant_q);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    snap_d  = snap_q;
    arb_en  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|ev_req) begin
          arb_en  = 1'b1;
          grant_d = arb_grant;
          snap_d  = ctl_lit;
          if ((ctl_lit == arb_grant) && |(ctl_green & arb_grant)) begin
            state_d = ST_EV_GREEN;
          end else if (|ctl_lit) begin
            state_d = ST_EXIT_YELLOW;
          end else begin
            state_d = ST_EXIT_RED;
          end
        end
      end
      ST_EXIT_YELLOW: if (elapsed >= YELLOW_CYCLES)  state_d = ST_EXIT_RED;
      ST_EXIT_RED:    if (elapsed >= ALL_RED_CYCLES) state_d = ST_EV_GREEN;
      ST_EV_GREEN: begin
        if ((elapsed >= MAX_EV_GREEN) || (!granted_req && (elapsed >= MIN_EV_GREEN))) begin
          state_d = ST_EV_YELLOW;
        end
      end
      ST_EV_YELLOW:   if (elapsed >= YELLOW_CYCLES)  state_d = ST_EV_RED;
      ST_EV_RED: begin
        if (elapsed >= ALL_RED_CYCLES) begin
          // The all-red just served already separates the next grant's green.
          if (|ev_req) begin
            arb_en  = 1'b1;
            grant_d = arb_grant;
            state_d = ST_EV_GREEN;
          end else begin
            grant_d = '0;
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
    endcase

    if ((state_d != state_q) || (state_q == ST_IDLE)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      grant_q <= '0;
      snap_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      snap_q  <= snap_d;
    end
  end

  always_comb begin
    out_l = '0;
    case (state_q)
      ST_IDLE: out_l = ctl_l;
      ST_EXIT_YELLOW: begin
        for (int i = 0; i < 4; i++) if (snap_q[i]) out_l[i] = LIGHT_YELLOW;
      end
      ST_EV_GREEN: begin
        for (int i = 0; i < 4; i++) if (grant_q[i]) out_l[i] = LIGHT_GREEN;
      end
      ST_EV_YELLOW: begin
        for (int i = 0; i < 4; i++) if (grant_q[i]) out_l[i] = LIGHT_YELLOW;
      end
      default: out_l = '0;
    endcase
    // Lamps stay dark-safe (all RED) for as long as reset is held.
    if (rst) out_l = '0;
  end

  assign NS_light       = out_l[DIR_NS];
  assign SN_light       = out_l[DIR_SN];
  assign EW_light       = out_l[DIR_EW];
  assign WE_light       = out_l[DIR_WE];
  assign ctl_hold       = (state_q != ST_IDLE);
  assign preempt_active = (state_q != ST_IDLE);
  assign ev_grant       = grant_q;
  assign current_state  = state_q;

endmodule

// File: tb/tb_emergency_preemption_controller.sv
// Bench for emergency_preemption_controller: directed scenarios plus a randomized run against a phase-list model.
module tb_emergency_preemption_controller;

  localparam int YC   = 3;
  localparam int RC   = 2;
  localparam int MING = 8;
  localparam int MAXG = 40;

  logic       clk = 1'b0;
  logic       rst;
  logic       EV_NS, EV_SN, EV_EW, EV_WE;
  logic [1:0] ctl_NS_light, ctl_SN_light, ctl_EW_light, ctl_WE_light;
  logic [1:0] NS_light, SN_light, EW_light, WE_light;
  logic       ctl_hold, preempt_active;
  logic [3:0] ev_grant;
  logic [2:0] current_state;
  logic [7:0] lights;

  int n_checks = 0;
  int n_errors = 0;

  assign lights = {WE_light, EW_light, SN_light, NS_light};

  always #5 clk = ~clk;

  emergency_preemption_controller #(
    .YELLOW_CYCLES  (YC),
    .ALL_RED_CYCLES (RC),
    .MIN_EV_GREEN   (MING),
    .MAX_EV_GREEN   (MAXG)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .EV_NS          (EV_NS),
    .EV_SN          (EV_SN),
    .EV_EW          (EV_EW),
    .EV_WE          (EV_WE),
    .ctl_NS_light   (ctl_NS_light),
    .ctl_SN_light   (ctl_SN_light),
    .ctl_EW_light   (ctl_EW_light),
    .ctl_WE_light   (ctl_WE_light),
    .NS_light       (NS_light),
    .SN_light       (SN_light),
    .EW_light       (EW_light),
    .WE_light       (WE_light),
    .ctl_hold       (ctl_hold),
    .preempt_active (preempt_active),
    .ev_grant       (ev_grant),
    .current_state  (current_state)
  );

  // ---------------- driver tasks ----------------
  task automatic set_ctl(input logic [7:0] v);
    {ctl_WE_light, ctl_EW_light, ctl_SN_light, ctl_NS_light} = v;
  endtask

  task automatic set_ev(input logic [3:0] v);
    {EV_WE, EV_EW, EV_SN, EV_NS} = v;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    set_ev(4'b0000);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int c = 0; c < 150 && current_state != 3'd0; c++) @(negedge clk);
    n_checks++;
    if (current_state !== 3'd0) begin
      n_errors++;
      $display("FAIL %s_idle_timeout: state %0d, required 0", name, current_state);
    end
  endtask

  // ---------------- directed scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    set_ev(4'b0000);
    set_ctl(8'h02);
    repeat (2) @(negedge clk);
    n_checks++;
    if (lights !== 8'h00) begin n_errors++; $display("FAIL reset_lights: got %h, required 00", lights); end
    n_checks++;
    if (current_state !== 3'd0) begin n_errors++; $display("FAIL reset_state: got %0d, required 0", current_state); end
    n_checks++;
    if (ev_grant !== 4'b0000) begin n_errors++; $display("FAIL reset_grant: got %b, required 0000", ev_grant); end
    n_checks++;
    if (ctl_hold !== 1'b0 || preempt_active !== 1'b0) begin
      n_errors++; $display("FAIL reset_hold: hold %b active %b, required 0 0", ctl_hold, preempt_active);
    end
    rst = 1'b0;
  endtask

  logic [7:0] pass_pats [4] = '{8'h02, 8'h10, 8'h80, 8'h00};

  task automatic test_passthrough();
    foreach (pass_pats[p]) begin
      @(negedge clk);
      set_ctl(pass_pats[p]);
      @(negedge clk);
      n_checks++;
      if (lights !== pass_pats[p]) begin
        n_errors++; $display("FAIL pass_lights: got %h, required %h", lights, pass_pats[p]);
      end
      n_checks++;
      if (ctl_hold !== 1'b0 || current_state !== 3'd0) begin
        n_errors++; $display("FAIL pass_idle: hold %b state %0d, required 0 0", ctl_hold, current_state);
      end
    end
  endtask

  task automatic test_ev_pulse();
    logic [7:0] exp_l;
    logic [3:0] exp_g;
    int hold_cnt;
    int t1, t2, t3, t4, t5;
    t1 = YC; t2 = t1 + RC; t3 = t2 + MING; t4 = t3 + YC; t5 = t4 + RC;
    hold_cnt = 0;
    @(negedge clk);
    set_ctl(8'h02);
    set_ev(4'b0100);
    for (int c = 0; c < t5 + 5; c++) begin
      @(negedge clk);
      if (c < t1)      exp_l = 8'h01;
      else if (c < t2) exp_l = 8'h00;
      else if (c < t3) exp_l = 8'h20;
      else if (c < t4) exp_l = 8'h10;
      else if (c < t5) exp_l = 8'h00;
      else             exp_l = 8'h02;
      exp_g = (c < t5) ? 4'b0100 : 4'b0000;
      n_checks++;
      if (lights !== exp_l) begin
        n_errors++; $display("FAIL pulse_lights c=%0d: got %h, required %h", c, lights, exp_l);
      end
      n_checks++;
      if (ev_grant !== exp_g) begin
        n_errors++; $display("FAIL pulse_grant c=%0d: got %b, required %b", c, ev_grant, exp_g);
      end
      if (ctl_hold === 1'b1) hold_cnt++;
      if (c == 2) set_ev(4'b0000);
    end
    n_checks++;
    if (hold_cnt != t5) begin n_errors++; $display("FAIL pulse_hold_len: got %0d, required %0d", hold_cnt, t5); end
  endtask

  task automatic test_direct_green();
    logic [2:0] exp_s;
    logic [7:0] exp_l;
    @(negedge clk);
    set_ctl(8'h02);
    set_ev(4'b0001);
    for (int c = 0; c <= MAXG + YC + RC; c++) begin
      @(negedge clk);
      if (c < MAXG)           begin exp_s = 3'd3; exp_l = 8'h02; end
      else if (c < MAXG + YC) begin exp_s = 3'd4; exp_l = 8'h01; end
      else if (c < MAXG + YC + RC) begin exp_s = 3'd5; exp_l = 8'h00; end
      else                    begin exp_s = 3'd3; exp_l = 8'h02; end
      n_checks++;
      if (current_state !== exp_s || lights !== exp_l) begin
        n_errors++;
        $display("FAIL direct c=%0d: state %0d lights %h, required %0d %h", c, current_state, lights, exp_s, exp_l);
      end
    end
    n_checks++;
    if (ev_grant !== 4'b0001) begin n_errors++; $display("FAIL direct_regrant: got %b, required 0001", ev_grant); end
    set_ev(4'b0000);
    wait_idle("direct");
  endtask

  task automatic test_back_to_back();
    logic [3:0] seq_q[$];
    logic [3:0] prev;
    bit idle_gap, done, we_ok;
    apply_reset();
    set_ctl(8'h00);
    set_ev(4'b1010);
    prev = 4'b0000; idle_gap = 0; done = 0; we_ok = 0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      if (ev_grant !== prev && ev_grant !== 4'b0000) seq_q.push_back(ev_grant);
      if (current_state === 3'd0 && seq_q.size() == 1) idle_gap = 1;
      if (ev_grant === 4'b1000 && current_state === 3'd3 && lights === 8'h80) we_ok = 1;
      if (c == 10) EV_SN = 1'b0;
      if (ev_grant === 4'b1000) EV_WE = 1'b0;
      if (current_state === 3'd0 && seq_q.size() >= 2) done = 1;
      prev = ev_grant;
    end
    n_checks++;
    if (!done) begin n_errors++; $display("FAIL b2b_timeout: grants seen %0d, required 2 then idle", seq_q.size()); end
    n_checks++;
    if (seq_q.size() != 2) begin n_errors++; $display("FAIL b2b_count: got %0d grants, required 2", seq_q.size()); end
    if (seq_q.size() >= 2) begin
      n_checks++;
      if (seq_q[0] !== 4'b0010) begin n_errors++; $display("FAIL b2b_first: got %b, required 0010", seq_q[0]); end
      n_checks++;
      if (seq_q[1] !== 4'b1000) begin n_errors++; $display("FAIL b2b_second: got %b, required 1000", seq_q[1]); end
    end
    n_checks++;
    if (idle_gap) begin n_errors++; $display("FAIL b2b_no_idle: idle seen 1, required 0"); end
    n_checks++;
    if (!we_ok) begin n_errors++; $display("FAIL b2b_we_green: seen 0, required 1"); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    set_ctl(8'h02);
    set_ev(4'b0100);
    for (int c = 0; c < 30 && current_state !== 3'd3; c++) @(negedge clk);
    n_checks++;
    if (current_state !== 3'd3) begin n_errors++; $display("FAIL rstmid_reach: state %0d, required 3", current_state); end
    rst = 1'b1;
    #1;
    n_checks++;
    if (lights !== 8'h00 || current_state !== 3'd0) begin
      n_errors++; $display("FAIL rstmid_now: lights %h state %0d, required 00 0", lights, current_state);
    end
    n_checks++;
    if (ev_grant !== 4'b0000 || ctl_hold !== 1'b0) begin
      n_errors++; $display("FAIL rstmid_grant: grant %b hold %b, required 0000 0", ev_grant, ctl_hold);
    end
    @(negedge clk);
    rst = 1'b0;
    set_ev(4'b1001);
    @(negedge clk);
    n_checks++;
    if (ev_grant !== 4'b0001) begin n_errors++; $display("FAIL rstmid_ptr: grant %b, required 0001", ev_grant); end
    set_ev(4'b0000);
    wait_idle("rstmid");
  endtask

  // ---------------- reference model (phase list) ----------------
  int   phase_q[$];
  bit   m_busy;
  int   m_grant, m_last, m_elapsed;
  logic [3:0] m_snap;
  int   c_dir, c_ph, c_cnt, c_glen;

  function automatic int phase_len(input int k);
    return (k == 1 || k == 4) ? YC : RC;
  endfunction

  task automatic rr_pick(input logic [3:0] ev, output int g);
    g = -1;
    for (int k = 1; k <= 4 && g < 0; k++) begin
      if (ev[(m_last + k) % 4]) g = (m_last + k) % 4;
    end
    m_last = g;
  endtask

  task automatic model_step(input logic [3:0] ev, input logic [7:0] ctl);
    logic [3:0] lit;
    int g;
    bit done, direct;
    for (int i = 0; i < 4; i++) lit[i] = (ctl[2*i +: 2] != 2'b00);
    if (!m_busy) begin
      if (ev != 4'b0000) begin
        rr_pick(ev, g);
        m_grant = g; m_snap = lit; m_busy = 1; m_elapsed = 0;
        phase_q.delete();
        direct = (lit == (4'b0001 << g)) && (ctl[2*g +: 2] == 2'b10);
        if (!direct) begin
          if (lit != 4'b0000) phase_q.push_back(1);
          phase_q.push_back(2);
        end
        phase_q.push_back(3); phase_q.push_back(4); phase_q.push_back(5);
      end
    end else begin
      m_elapsed++;
      if (phase_q[0] == 3) done = (m_elapsed >= MAXG) || (!ev[m_grant] && m_elapsed >= MING);
      else                 done = (m_elapsed >= phase_len(phase_q[0]));
      if (done) begin
        void'(phase_q.pop_front());
        m_elapsed = 0;
        if (phase_q.size() == 0) begin
          if (ev != 4'b0000) begin
            rr_pick(ev, g);
            m_grant = g;
            phase_q.push_back(3); phase_q.push_back(4); phase_q.push_back(5);
          end else begin
            m_busy = 0;
          end
        end
      end
    end
  endtask

  function automatic logic [7:0] ctl_pack();
    logic [7:0] v;
    v = 8'h00;
    if (c_ph == 0)      v[2*c_dir +: 2] = 2'b10;
    else if (c_ph == 1) v[2*c_dir +: 2] = 2'b01;
    return v;
  endfunction

  task automatic ctl_step();
    c_cnt++;
    if (c_ph == 0 && c_cnt >= c_glen) begin c_ph = 1; c_cnt = 0; end
    else if (c_ph == 1 && c_cnt >= YC) begin c_ph = 2; c_cnt = 0; end
    else if (c_ph == 2 && c_cnt >= RC) begin
      c_ph = 0; c_cnt = 0; c_dir = (c_dir + 1) % 4; c_glen = $urandom_range(3, 10);
    end
  endtask

  task automatic test_random();
    logic [3:0] ev_cur;
    logic [7:0] exp_l, ctl_v;
    logic [3:0] exp_g;
    logic [2:0] exp_s;
    int last_green, red_run, ngreen, gi;
    bit yel_seen;
    apply_reset();
    m_busy = 0; m_last = 3; m_grant = 0; m_elapsed = 0; m_snap = '0; phase_q.delete();
    c_dir = 0; c_ph = 0; c_cnt = 0; c_glen = 6;
    ev_cur = 4'b0000;
    ctl_v = ctl_pack();
    set_ctl(ctl_v);
    set_ev(ev_cur);
    model_step(ev_cur, ctl_v);
    last_green = -1; red_run = 0; yel_seen = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      exp_l = 8'h00; exp_g = 4'b0000; exp_s = 3'd0;
      if (!m_busy) begin
        exp_l = ctl_v;
      end else begin
        exp_s = 3'(phase_q[0]);
        exp_g = 4'b0001 << m_grant;
        case (phase_q[0])
          1: for (int i = 0; i < 4; i++) if (m_snap[i]) exp_l[2*i +: 2] = 2'b01;
          3: exp_l[2*m_grant +: 2] = 2'b10;
          4: exp_l[2*m_grant +: 2] = 2'b01;
          default: exp_l = 8'h00;
        endcase
      end
      n_checks++;
      if (lights !== exp_l) begin n_errors++; $display("FAIL rand_lights cyc=%0d: got %h, required %h", cyc, lights, exp_l); end
      n_checks++;
      if (ev_grant !== exp_g) begin n_errors++; $display("FAIL rand_grant cyc=%0d: got %b, required %b", cyc, ev_grant, exp_g); end
      n_checks++;
      if (current_state !== exp_s) begin n_errors++; $display("FAIL rand_state cyc=%0d: got %0d, required %0d", cyc, current_state, exp_s); end
      n_checks++;
      if (ctl_hold !== m_busy || preempt_active !== m_busy) begin
        n_errors++; $display("FAIL rand_hold cyc=%0d: hold %b active %b, required %b", cyc, ctl_hold, preempt_active, m_busy);
      end

      // Safety: single green, and a change of green approach needs yellow then >=2 all-red.
      ngreen = 0; gi = -1;
      for (int i = 0; i < 4; i++) if (lights[2*i +: 2] === 2'b10) begin ngreen++; gi = i; end
      n_checks++;
      if (ngreen > 1) begin n_errors++; $display("FAIL safety_two_green cyc=%0d: greens %0d, required <=1", cyc, ngreen); end
      if (ngreen == 1) begin
        if (last_green >= 0 && gi != last_green) begin
          n_checks++;
          if (!(yel_seen && red_run >= RC)) begin
            n_errors++;
            $display("FAIL safety_clearance cyc=%0d: yellow %0b red_run %0d, required 1 >=%0d", cyc, yel_seen, red_run, RC);
          end
        end
        last_green = gi; yel_seen = 0;
      end else if (last_green >= 0 && lights[2*last_green +: 2] === 2'b01) begin
        yel_seen = 1;
      end
      red_run = (lights === 8'h00) ? red_run + 1 : 0;

      for (int i = 0; i < 4; i++) begin
        if (ev_cur[i]) begin
          if ($urandom_range(0, 19) == 0) ev_cur[i] = 1'b0;
        end else if ($urandom_range(0, 59) == 0) begin
          ev_cur[i] = 1'b1;
        end
      end
      if (!m_busy) ctl_step();
      ctl_v = ctl_pack();
      set_ctl(ctl_v);
      set_ev(ev_cur);
      model_step(ev_cur, ctl_v);
    end
    set_ev(4'b0000);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_passthrough();
    test_ev_pulse();
    test_direct_green();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/emergency_preemption_controller.md
# emergency_preemption_controller

Sits between `adaptive_traffic_light_controller` and the lamp drivers. It passes the controller's lights through unchanged until an emergency-vehicle request arrives on any approach (NS, SN, EW, WE). On a request it freezes the main controller and runs a safe clearance sequence: yellow, then all-red, then emergency green for the granted approach, then clearance again. Simultaneous or back-to-back requests are shared by a round-robin arbiter.

## Interface
- `YELLOW_CYCLES`, default 3: duration of every yellow interval, in cycles.
- `ALL_RED_CYCLES`, default 2: duration of every all-red interval.
- `MIN_EV_GREEN`, default 8: minimum emergency green, even if the request drops early.
- `MAX_EV_GREEN`, default 40: maximum emergency green, even if the request stays high.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `EV_NS`, `EV_SN`, `EV_EW`, `EV_WE` in 1 each: emergency request, level, held by the detector.
- `ctl_NS_light`, `ctl_SN_light`, `ctl_EW_light`, `ctl_WE_light` in 2 each: lights from the main controller.
- `NS_light`, `SN_light`, `EW_light`, `WE_light` out 2 each: lights to the lamp drivers.
- `ctl_hold` out 1: freezes the main controller's state and timers while high.
- `preempt_active` out 1: high in every state except IDLE.
- `ev_grant` out 4: one-hot granted approach, bit order {WE,EW,SN,NS}; 0 when idle.
- `current_state` out 3: FSM state, for debug and the bench.

## Operation
- Light encoding: RED=2'b00, YELLOW=2'b01, GREEN=2'b10. Direction indices: NS=0, SN=1, EW=2, WE=3.
- States: IDLE=0, EXIT_YELLOW=1, EXIT_RED=2, EV_GREEN=3, EV_YELLOW=4, EV_RED=5.
- **IDLE**
  - Outputs equal the `ctl_*` lights combinationally.
  - If any EV_* is high, the arbiter grants one approach and the grant is latched.
  - Next state:
    - EV_GREEN if the granted approach is the only GREEN/YELLOW in the ctl lights and it is GREEN.
    - Otherwise EXIT_YELLOW if any ctl light is GREEN or YELLOW.
    - Otherwise EXIT_RED.
  - The ctl lights are snapshotted on the same edge.
- **EXIT_YELLOW**: snapshot GREEN/YELLOW approaches show YELLOW, all others RED. Lasts YELLOW_CYCLES, then EXIT_RED.
- **EXIT_RED**: all RED for ALL_RED_CYCLES, then EV_GREEN.
- **EV_GREEN**
  - Granted approach GREEN, others RED.
  - Exit to EV_YELLOW when the count reaches MAX_EV_GREEN, or when the granted EV is low and the count ≥ MIN_EV_GREEN.
- **EV_YELLOW**: granted approach YELLOW for YELLOW_CYCLES, then EV_RED.
- **EV_RED**: all RED for ALL_RED_CYCLES. At the end:
  - If any EV is high, the arbiter issues a new grant and the FSM goes directly to EV_GREEN. The all-red is already satisfied.
  - Otherwise IDLE, clearing `ev_grant`.
- **Arbiter**
  - Round-robin over indices 0..3; priority starts one past the last grant. After reset it starts at NS.
  - The pointer advances only when a grant is issued.
  - A request raised during EV_GREEN on a non-granted approach waits; it does not shorten the current green.
- `ctl_hold` = `preempt_active` = (state != IDLE). The controller resumes from its frozen state on the cycle after return to IDLE.
- EV requests that drop in EXIT_* keep the latched grant: the sequence completes with MIN_EV_GREEN.

## Timing
- Reset, asynchronous:
  - state IDLE; counter 0; `ev_grant` 0; arbiter pointer NS.
  - `ctl_hold` 0, `preempt_active` 0.
  - While `rst` is high, all four lights are forced RED regardless of the ctl inputs.
- Reset mid-preemption returns to IDLE immediately and drops `ctl_hold`.
- Latency: an EV seen high at edge N gives the override lights in the cycle after edge N.
- Counter:
  - Width $clog2(MAX_EV_GREEN+1).
  - Cleared on every state entry; increments each cycle in timed states.
  - A state timed T cycles is occupied for exactly T cycles.
- Outputs are decoded from registered state, grant and snapshot, except the IDLE pass-through.
- The sequence never permits GREEN on two approaches, or GREEN directly following another approach's GREEN without YELLOW plus ALL_RED_CYCLES between.

## Structure
- `traffic_pkg`: light encodings, direction indices, state encoding. Shared with `adaptive_traffic_light_controller`.
- Sub-module `rr_arbiter4`:
  - Inputs: 4-bit requests, a `grant_en` strobe.
  - Outputs: one-hot grant.
  - Holds the rotating pointer internally.

## Test plan
- Pass-through: no EV, ctl NS=GREEN, others RED → outputs match ctl, `ctl_hold`=0, state 0.
- EV_EW pulse held 3 cycles, ctl NS GREEN:
  - NS YELLOW for 3 cycles, all RED for 2, EW GREEN for 8 cycles (MIN), EW YELLOW for 3, all RED for 2, then IDLE.
  - `ctl_hold` is high for 18 cycles.
- EV_NS held continuously with NS already the only GREEN → direct EV_GREEN, and NS GREEN ends at exactly 40 cycles.
- EV_SN and EV_WE raised on the same edge after reset:
  - SN is served first, then WE directly from EV_RED without IDLE.
  - `ev_grant` goes 4'b0010, then 4'b1000.
- Reset asserted in EV_GREEN → all lights RED immediately, state 0, `ev_grant` 0, pointer back to NS.
- Safety assertion, checked throughout a random EV/ctl run:
  - No two approaches GREEN at once.
  - Every change between approaches' GREEN passes through YELLOW, then ≥2 all-RED cycles.
